// File: rtl/serv_rf_serdes_pkg.sv
// Shared definitions for the register-file serializer/deserializer.
// Holds the sequencer state encodings and the default datapath and
// register-address widths used by serv_rf_serdes and its sub-modules.
package serv_rf_serdes_pkg;

    localparam int SD_W  = 32;  // datapath width, also bits per ALU phase
    localparam int SD_AW = 5;   // register index width

    typedef enum logic [2:0] {
        SD_IDLE  = 3'd0,
        SD_READ  = 3'd1,
        SD_INIT  = 3'd2,
        SD_RUN   = 3'd3,
        SD_WRITE = 3'd4,
        SD_DONE  = 3'd5
    } sd_state_t;

endpackage

// File: rtl/serv_rf_serdes_rot.sv
// serv_rot_reg: W-bit parallel-load, rotate-right register with a serial tap.
// Rotating (rather than shifting) means that after W rotations the register
// holds the original word again, so a second pass can stream it unchanged.
// Ports:
//   clk      clock
//   i_rst_n  asynchronous active-low reset, clears the register
//   i_load   load i_d (takes priority over rotate)
//   i_d      parallel load data
//   i_rot    rotate right by one bit
//   o_tap    bit 0 of the register (current serial bit)
module serv_rot_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    input  logic         i_rot,
    output logic         o_tap
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q <= '0;
        end else if (i_load) begin
            q <= i_d;
        end else if (i_rot) begin
            q <= {q[0], q[W-1:1]};
        end
    end

    assign o_tap = q[0];

endmodule

// File: rtl/serv_rf_serdes.sv
// serv_rf_serdes: bit-serial operand sequencer between the parallel register
// file and the serial ALU. Reads rs1/rs2 as words, streams them LSB-first
// (optional INIT pass, then RUN pass), collects the serial rd result into a
// word and writes it back unless rd is x0 or write-back is disabled.
// Ports:
//   clk, i_rst_n                       clock, async active-low reset
//   i_start, i_init_pass, i_rs*_addr,  operation request, sampled in IDLE only
//   i_rd_addr, i_rd_en
//   o_rf_rreq, o_rf_raddr1/2,          register-file read handshake
//   i_rf_rvalid, i_rf_rdata1/2
//   o_rf_wreq, o_rf_waddr, o_rf_wdata, register-file write handshake
//   i_rf_wready
//   o_rs1, o_rs2, o_init, o_en,        serial ALU interface
//   o_cnt_done, i_rd
//   o_busy, o_done                     status
module serv_rf_serdes
    import serv_rf_serdes_pkg::*;
#(
    parameter int W  = SD_W,
    parameter int AW = SD_AW
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_init_pass,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic [AW-1:0] i_rs2_addr,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_rd_en,
    output logic          o_rf_rreq,
    output logic [AW-1:0] o_rf_raddr1,
    output logic [AW-1:0] o_rf_raddr2,
    input  logic          i_rf_rvalid,
    input  logic [W-1:0]  i_rf_rdata1,
    input  logic [W-1:0]  i_rf_rdata2,
    output logic          o_rf_wreq,
    output logic [AW-1:0] o_rf_waddr,
    output logic [W-1:0]  o_rf_wdata,
    input  logic          i_rf_wready,
    output logic          o_rs1,
    output logic          o_rs2,
    output logic          o_init,
    output logic          o_en,
    output logic          o_cnt_done,
    input  logic          i_rd,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    sd_state_t     state;
    sd_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic          init_pass_q;
    logic          rd_en_q;
    logic [AW-1:0] rd_addr_q;
    logic [W-1:0]  rd_q;
    logic          rs1_tap;
    logic          rs2_tap;
    logic          streaming;
    logic          load_ops;
    logic          enter_phase;

    assign streaming   = (state == SD_INIT) || (state == SD_RUN);
    assign load_ops    = (state == SD_READ) && i_rf_rvalid;
    // Counter restarts whenever a new phase begins (including INIT -> RUN).
    assign enter_phase = (state_nxt != state) &&
                         ((state_nxt == SD_INIT) || (state_nxt == SD_RUN));

    always_comb begin
        state_nxt = state;
        case (state)
            SD_IDLE:  if (i_start) state_nxt = SD_READ;
            SD_READ:  if (i_rf_rvalid) state_nxt = init_pass_q ? SD_INIT : SD_RUN;
            SD_INIT:  if (cnt == CNT_LAST) state_nxt = SD_RUN;
            SD_RUN:   if (cnt == CNT_LAST)
                          state_nxt = (rd_en_q && (rd_addr_q != '0)) ? SD_WRITE : SD_DONE;
            SD_WRITE: if (i_rf_wready) state_nxt = SD_DONE;
            SD_DONE:  state_nxt = SD_IDLE;
            default:  state_nxt = SD_IDLE;
        endcase
    end

    // Phase outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= SD_IDLE;
            cnt         <= '0;
            init_pass_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_q        <= '0;
            o_rf_raddr1 <= '0;
            o_rf_raddr2 <= '0;
            o_rf_rreq   <= 1'b0;
            o_rf_wreq   <= 1'b0;
            o_init      <= 1'b0;
            o_en        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_rf_rreq <= (state_nxt == SD_READ);
            o_rf_wreq <= (state_nxt == SD_WRITE);
            o_init    <= (state_nxt == SD_INIT);
            o_en      <= (state_nxt == SD_RUN);
            o_busy    <= (state_nxt != SD_IDLE);
            o_done    <= (state_nxt == SD_DONE);

            if ((state == SD_IDLE) && i_start) begin
                o_rf_raddr1 <= i_rs1_addr;
                o_rf_raddr2 <= i_rs2_addr;
                rd_addr_q   <= i_rd_addr;
                rd_en_q     <= i_rd_en;
                init_pass_q <= i_init_pass;
            end

            if (enter_phase) begin
                cnt <= '0;
            end else if (streaming) begin
                cnt <= cnt + CW'(1);
            end

            // Result enters at the MSB so bit k ends up holding RUN cycle k.
            if (state == SD_RUN) begin
                rd_q <= {i_rd, rd_q[W-1:1]};
            end
        end
    end

    serv_rot_reg #(.W(W)) u_rot_rs1 (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_load  (load_ops),
        .i_d     (i_rf_rdata1),
        .i_rot   (streaming),
        .o_tap   (rs1_tap)
    );

    serv_rot_reg #(.W(W)) u_rot_rs2 (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_load  (load_ops),
        .i_d     (i_rf_rdata2),
        .i_rot   (streaming),
        .o_tap   (rs2_tap)
    );

    assign o_rs1      = rs1_tap & (o_init | o_en);
    assign o_rs2      = rs2_tap & (o_init | o_en);
    assign o_cnt_done = (o_init | o_en) && (cnt == CNT_LAST);
    assign o_rf_waddr = rd_addr_q;
    assign o_rf_wdata = o_rf_wreq ? rd_q : '0;

endmodule

// File: tb/tb_serv_rf_serdes.sv
// Testbench for serv_rf_serdes: a driver issues operations and pushes the
// expected ALU bit stream, write-back and completion events into a
// scoreboard queue; a monitor pops and compares whenever the DUT presents
// a serial bit, a write request or a done pulse.
module tb_serv_rf_serdes;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic          i_init_pass;
    logic [AW-1:0] i_rs1_addr;
    logic [AW-1:0] i_rs2_addr;
    logic [AW-1:0] i_rd_addr;
    logic          i_rd_en;
    logic          o_rf_rreq;
    logic [AW-1:0] o_rf_raddr1;
    logic [AW-1:0] o_rf_raddr2;
    logic          i_rf_rvalid;
    logic [W-1:0]  i_rf_rdata1;
    logic [W-1:0]  i_rf_rdata2;
    logic          o_rf_wreq;
    logic [AW-1:0] o_rf_waddr;
    logic [W-1:0]  o_rf_wdata;
    logic          i_rf_wready;
    logic          o_rs1;
    logic          o_rs2;
    logic          o_init;
    logic          o_en;
    logic          o_cnt_done;
    logic          i_rd;
    logic          o_busy;
    logic          o_done;

    always #5 clk = ~clk;

    serv_rf_serdes #(.W(W), .AW(AW)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_init_pass (i_init_pass),
        .i_rs1_addr  (i_rs1_addr),
        .i_rs2_addr  (i_rs2_addr),
        .i_rd_addr   (i_rd_addr),
        .i_rd_en     (i_rd_en),
        .o_rf_rreq   (o_rf_rreq),
        .o_rf_raddr1 (o_rf_raddr1),
        .o_rf_raddr2 (o_rf_raddr2),
        .i_rf_rvalid (i_rf_rvalid),
        .i_rf_rdata1 (i_rf_rdata1),
        .i_rf_rdata2 (i_rf_rdata2),
        .o_rf_wreq   (o_rf_wreq),
        .o_rf_waddr  (o_rf_waddr),
        .o_rf_wdata  (o_rf_wdata),
        .i_rf_wready (i_rf_wready),
        .o_rs1       (o_rs1),
        .o_rs2       (o_rs2),
        .o_init      (o_init),
        .o_en        (o_en),
        .o_cnt_done  (o_cnt_done),
        .i_rd        (i_rd),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef enum int {EV_INIT, EV_RUN, EV_WRITE, EV_DONE} ev_kind_e;

    typedef struct {
        ev_kind_e      kind;
        logic [2:0]    bits;   // {rs1, rs2, cnt_done}
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ev_t;

    ev_t          sbq[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] alu_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input logic [2:0] b,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
        ev_t e;
        e.kind = k;
        e.bits = b;
        e.addr = a;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic pop_ev(input string what, output ev_t e, output bit ok);
        if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            ok = 1'b0;
            e.kind = EV_DONE;
            e.bits = '0;
            e.addr = '0;
            e.data = '0;
            $display("FAIL %s: DUT event with nothing expected at %0t", what, $time);
        end else begin
            e  = sbq.pop_front();
            ok = 1'b1;
        end
    endtask

    // Serial ALU model: returns bit k of the operation's word result in RUN cycle k.
    initial begin
        int k;
        k = 0;
        i_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (o_en) begin
                i_rd = alu_word[k & (W - 1)];
                k++;
            end else begin
                k = 0;
                i_rd = 1'b0;
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pops on DUT events.
    initial begin
        ev_t e;
        bit  ok;
        logic prev_wreq;
        prev_wreq = 1'b0;
        forever begin
            @(negedge clk);
            if (i_rst_n) begin
                check("init_en_overlap", o_init & o_en, 0);
                if (o_init || o_en) begin
                    pop_ev("serial_bit", e, ok);
                    if (ok) begin
                        check("phase_kind", 64'(o_init ? EV_INIT : EV_RUN), 64'(e.kind));
                        check("serial_bits", {o_rs1, o_rs2, o_cnt_done}, e.bits);
                    end
                end else begin
                    check("quiet_serial", {o_rs1, o_rs2, o_cnt_done}, 0);
                end
                if (o_rf_wreq && !prev_wreq) begin
                    pop_ev("write_req", e, ok);
                    if (ok) begin
                        check("write_kind", 64'(EV_WRITE), 64'(e.kind));
                        check("write_addr", o_rf_waddr, e.addr);
                        check("write_data", o_rf_wdata, e.data);
                    end
                end
                if (!o_rf_wreq) check("wdata_idle_zero", o_rf_wdata, 0);
                if (o_done) begin
                    pop_ev("done_pulse", e, ok);
                    if (ok) check("done_kind", 64'(EV_DONE), 64'(e.kind));
                end
                prev_wreq = o_rf_wreq;
            end else begin
                prev_wreq = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic [AW-1:0] rd, input logic rden, input logic ini,
                          input int rv_dly, input int wr_dly, input bit noise, input bit hold);
        int   cyc;
        logic wr_exp;
        logic prev_last;
        logic [W-1:0] sum;
        sum    = a + b;
        wr_exp = rden && (rd != '0);
        for (int k = 0; k < W; k++)
            if (ini) push_ev(EV_INIT, {a[k], b[k], (k == W - 1)}, '0, '0);
        for (int k = 0; k < W; k++)
            push_ev(EV_RUN, {a[k], b[k], (k == W - 1)}, '0, '0);
        if (wr_exp) push_ev(EV_WRITE, 3'b000, rd, sum);
        push_ev(EV_DONE, 3'b000, '0, '0);
        alu_word = sum;

        i_start     = 1'b1;
        i_init_pass = ini;
        i_rs1_addr  = r1;
        i_rs2_addr  = r2;
        i_rd_addr   = rd;
        i_rd_en     = rden;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_rf_rreq && cyc < 8);
        if (!hold) i_start = 1'b0;
        check("start_to_rreq", cyc, 1);
        check("raddr1", o_rf_raddr1, r1);
        check("raddr2", o_rf_raddr2, r2);
        check("busy_in_read", o_busy, 1);
        // Scramble the sampled inputs: they must already be latched.
        i_rs1_addr = AW'($urandom);
        i_rs2_addr = AW'($urandom);
        i_rd_addr  = AW'($urandom);
        i_init_pass = 1'($urandom);
        i_rd_en    = 1'($urandom);

        for (int i = 0; i < rv_dly; i++) begin
            if (noise) i_start = 1'($urandom);
            @(negedge clk);
            check("rreq_held", o_rf_rreq, 1);
            check("raddr1_held", o_rf_raddr1, r1);
            check("raddr2_held", o_rf_raddr2, r2);
        end
        i_rf_rvalid = 1'b1;
        i_rf_rdata1 = a;
        i_rf_rdata2 = b;
        @(negedge clk);
        i_rf_rvalid = 1'b0;
        i_rf_rdata1 = $urandom;
        i_rf_rdata2 = $urandom;
        check("first_bit_init", o_init, ini);
        check("first_bit_en", o_en, !ini);

        cyc = 0;
        prev_last = 1'b0;
        while (!o_rf_wreq && !o_done && cyc < 3 * W) begin
            prev_last = o_en && o_cnt_done;
            if (noise) i_start = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("wreq_present", o_rf_wreq, wr_exp);
        check("end_follows_last_run_bit", prev_last, 1);
        if (o_rf_wreq) begin
            for (int i = 0; i < wr_dly; i++) begin
                if (noise) i_start = 1'($urandom);
                @(negedge clk);
                check("wreq_held", o_rf_wreq, 1);
                check("waddr_held", o_rf_waddr, rd);
                check("wdata_held", o_rf_wdata, sum);
            end
            i_rf_wready = 1'b1;
            @(negedge clk);
            i_rf_wready = 1'b0;
        end
        check("done_pulse", o_done, 1);
        i_start = hold;
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("idle_not_busy", o_busy, 0);
    endtask

    task automatic reset_mid_run();
        push_ev(EV_RUN, 3'b000, '0, '0);  // stale entries, flushed before use
        for (int k = 1; k < W; k++) push_ev(EV_RUN, 3'b000, '0, '0);
        sbq.delete();
        for (int k = 0; k < W; k++) push_ev(EV_RUN, {1'b1, 1'(k & 1), (k == W - 1)}, '0, '0);
        push_ev(EV_WRITE, 3'b000, 5'd9, '0);
        push_ev(EV_DONE, 3'b000, '0, '0);
        alu_word = 32'h1234_5678;
        i_start     = 1'b1;
        i_init_pass = 1'b0;
        i_rs1_addr  = 5'd1;
        i_rs2_addr  = 5'd2;
        i_rd_addr   = 5'd9;
        i_rd_en     = 1'b1;
        @(negedge clk);
        i_start     = 1'b0;
        i_rf_rvalid = 1'b1;
        i_rf_rdata1 = 32'hFFFF_FFFF;
        i_rf_rdata2 = 32'hAAAA_AAAA;
        @(negedge clk);
        i_rf_rvalid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_in_run", o_en, 1);
        #2;
        i_rst_n = 1'b0;
        sbq.delete();
        #1;
        check("rst_async_ctrl", {o_rf_rreq, o_rf_wreq, o_init, o_en, o_cnt_done, o_busy, o_done}, 0);
        check("rst_async_serial", {o_rs1, o_rs2}, 0);
        check("rst_async_addr", {o_rf_raddr1, o_rf_raddr2, o_rf_waddr}, 0);
        check("rst_async_wdata", o_rf_wdata, 0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (2 * W + 4) @(negedge clk);
        check("post_abort_idle", {o_busy, o_rf_wreq, o_done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_init_pass = 1'b0;
        i_rs1_addr  = '0;
        i_rs2_addr  = '0;
        i_rd_addr   = '0;
        i_rd_en     = 1'b0;
        i_rf_rvalid = 1'b0;
        i_rf_rdata1 = '0;
        i_rf_rdata2 = '0;
        i_rf_wready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {o_rf_rreq, o_rf_wreq, o_init, o_en, o_cnt_done, o_busy, o_done}, 0);
        check("reset_data", {o_rs1, o_rs2, o_rf_raddr1, o_rf_raddr2, o_rf_waddr}, 0);
        check("reset_wdata", o_rf_wdata, 0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // Add path, read data in the first READ cycle.
        run_op(32'h0000_0003, 32'h0000_0005, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        // Init pass streams the same operand twice.
        run_op(32'hDEAD_BEEF, 32'h0F0F_1234, 5'd4, 5'd6, 5'd8, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        // Writes to x0 are suppressed.
        run_op(32'h1357_9BDF, 32'h2468_ACE0, 5'd10, 5'd11, 5'd0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
        // Write-back disabled.
        run_op(32'h8000_0001, 32'h7FFF_FFFF, 5'd12, 5'd13, 5'd14, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        // Handshake stalls with stray start pulses while busy.
        run_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 5'd21, 5'd22, 5'd23, 1'b1, 1'b0, 4, 3, 1'b1, 1'b0);

        reset_mid_run();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 5'd30, 5'd29, 1'b1, 1'b0, 2, 2, 1'b0, 1'b0);

        // Back-to-back with start held high: IDLE lasts exactly one cycle.
        run_op(32'h0000_00FF, 32'h0000_0F00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        run_op(32'h1111_1111, 32'h2222_2222, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
        run_op(32'h3333_3333, 32'h4444_4444, 5'd7, 5'd8, 5'd0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_op($urandom, $urandom, AW'($urandom), AW'($urandom),
                   AW'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'b1, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
